// File: rtl/compare_arbiter.sv
// rtl/compare_arbiter.sv - round-robin arbiter feeding one registered signed/unsigned comparator
module compare_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_a_i,
    input  logic [N_REQ*WIDTH-1:0] req_b_i,
    input  logic [N_REQ-1:0]       req_signed_i,
    input  logic [N_REQ*3-1:0]     req_op_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic                   rsp_q_o
);

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              signed_q;
    logic [2:0]        op_q;
    logic              rsp_valid_q, rsp_q_q;
    logic [ID_W-1:0]   rsp_id_q;

    logic              hi_found, any_valid;
    logic [ID_W-1:0]   hi_idx, lo_idx, grant_idx, ptr_inc;
    logic [WIDTH-1:0]  sel_a, sel_b;
    logic              sel_s;
    logic [2:0]        sel_op;

    // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_found  = 1'b0;
        any_valid = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                any_valid = 1'b1;
                lo_idx    = ID_W'(k);
                if (ID_W'(k) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(k);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_s  = 1'b0;
        sel_op = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == grant_idx) begin
                sel_a  = req_a_i[k*WIDTH +: WIDTH];
                sel_b  = req_b_i[k*WIDTH +: WIDTH];
                sel_s  = req_signed_i[k];
                sel_op = req_op_i[k*3 +: 3];
            end
        end
    end

    assign req_ready_o = (state_q == IDLE && !rst && any_valid)
                         ? (N_REQ'(1) << grant_idx) : '0;

    // One extra bit lets a single signed compare cover both modes without overflow.
    logic signed [WIDTH:0] a_ext, b_ext;
    logic                  lt, eq, result;

    assign a_ext = {signed_q & a_q[WIDTH-1], a_q};
    assign b_ext = {signed_q & b_q[WIDTH-1], b_q};
    assign lt    = a_ext < b_ext;
    assign eq    = (a_q == b_q);

    always_comb begin
        case (op_q)
            3'd0:    result = lt;
            3'd1:    result = lt | eq;
            3'd2:    result = ~lt & ~eq;
            3'd3:    result = ~lt;
            3'd4:    result = eq;
            3'd5:    result = ~eq;
            default: result = 1'b0;
        endcase
    end

    assign ptr_inc = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        signed_q <= sel_s;
                        op_q     <= sel_op;
                        id_q     <= grant_idx;
                        state_q  <= CMP;
                    end
                end
                CMP: begin
                    rsp_q_q     <= result;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= ptr_inc;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_q_o     = rsp_q_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// tb/tb_compare_arbiter.sv - scoreboard bench for compare_arbiter (32-bit x4 and 16-bit x2 instances)
module tb_compare_arbiter;
    localparam int W = 32, N = 4, IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_signed;
    logic [N*W-1:0]  req_a, req_b;
    logic [N*3-1:0]  req_op;
    logic            rsp_valid, rsp_ready, rsp_q;
    logic [IW-1:0]   rsp_id;

    logic [1:0]      v16, r16, s16;
    logic [31:0]     a16, b16;
    logic [5:0]      op16;
    logic            rv16, q16, id16;
    logic            rr16 = 1'b1;

    always #5 clk = ~clk;

    compare_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_signed_i(req_signed), .req_op_i(req_op),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_q_o(rsp_q)
    );

    compare_arbiter #(.WIDTH(16), .N_REQ(2)) u16 (
        .clk(clk), .rst(rst),
        .req_valid_i(v16), .req_ready_o(r16),
        .req_a_i(a16), .req_b_i(b16), .req_signed_i(s16), .req_op_i(op16),
        .rsp_valid_o(rv16), .rsp_ready_i(rr16), .rsp_id_o(id16), .rsp_q_o(q16)
    );

    int          n_assert = 0, n_fail = 0, cyc = 0, last_hs = -100, n_grants = 0;
    logic [7:0]  sb[$];
    int          grant_ids[$];
    int          grant_cyc[$];
    logic        prev_valid = 1'b0;
    logic        last_q = 1'b0;
    int          last_id = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cmp_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic s, input logic [2:0] op, input int w);
        longint lim, va, vb;
        lim = longint'(1) << w;
        va  = longint'(a) & (lim - 1);
        vb  = longint'(b) & (lim - 1);
        if (s && va >= lim / 2) va = va - lim;
        if (s && vb >= lim / 2) vb = vb - lim;
        case (op)
            3'd0: return va <  vb;
            3'd1: return va <= vb;
            3'd2: return va >  vb;
            3'd3: return va >= vb;
            3'd4: return va == vb;
            3'd5: return va != vb;
            default: return 1'b0;
        endcase
    endfunction

    // Sample at negedge, then return just after the next rising edge for driving.
    task automatic cycle();
        logic [7:0] e;
        int g;
        @(negedge clk);
        cyc++;
        if (rsp_valid && !prev_valid) check("latency", 64'(cyc - last_hs), 64'd2);
        prev_valid = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e[7:1]));
                check("rsp_q", 64'(rsp_q), 64'(e[0]));
            end
            last_id = int'(rsp_id);
            last_q  = rsp_q;
        end
        if ((req_ready & req_valid) != '0) begin
            check("ready_onehot", 64'($countones(req_ready)), 64'd1);
            g = 0;
            for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
            sb.push_back({7'(g), cmp_model(req_a[g*W +: W], req_b[g*W +: W],
                                           req_signed[g], req_op[g*3 +: 3], W)});
            grant_ids.push_back(g);
            grant_cyc.push_back(cyc);
            last_hs = cyc;
            n_grants++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [2:0] op);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
        req_signed[k]   = s;
        req_op[k*3 +: 3] = op;
        req_valid[k]    = 1'b1;
    endtask

    task automatic wait_grants(input int target);
        int t = 0;
        while (n_grants < target && t < 30) begin
            cycle();
            t++;
        end
        if (n_grants < target) check("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [2:0] op);
        set_req(k, a, b, s, op);
        wait_grants(n_grants + 1);
        req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            cycle();
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        sb.delete();
        cycle();
        rst = 1'b0;
        prev_valid = 1'b0;
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [2:0] op, input logic exp);
        logic got = 1'b0;
        a16 = {16'h0, a};
        b16 = {16'h0, b};
        s16 = {1'b0, s};
        op16 = {3'b0, op};
        v16 = 2'b01;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (r16[0]) got = 1'b1;
            @(posedge clk);
            #1;
        end
        v16 = 2'b00;
        check({tag, "_grant"}, 64'(got), 64'd1);
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (rv16) begin
                got = 1'b1;
                check(tag, 64'(q16), 64'(exp));
                check({tag, "_id"}, 64'(id16), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_rsp"}, 64'(got), 64'd1);
    endtask

    initial begin
        logic [7:0] sweep_exp;
        int         rr_exp[5];
        int         g0;
        logic       bp_q;

        sweep_exp = 8'b0001_1010;
        rr_exp    = '{0, 1, 2, 3, 0};
        req_a = '0; req_b = '0; req_signed = '0; req_op = '0;
        v16 = '0; a16 = '0; b16 = '0; s16 = '0; op16 = '0;
        rsp_ready = 1'b1;
        rst = 1'b1;
        req_valid = '1;
        cycle();
        cycle();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_q", 64'(rsp_q), 64'd0);
        req_valid = '0;
        sb.delete();
        rst = 1'b0;

        do_req(0, 32'd5, 32'hFFFF_FFFF, 1'b0, 3'd0);
        drain();
        check("ult_q", 64'(last_q), 64'd1);
        check("ult_id", 64'(last_id), 64'd0);
        do_req(0, 32'd5, 32'hFFFF_FFFF, 1'b1, 3'd0);
        drain();
        check("slt_q", 64'(last_q), 64'd0);

        for (int s = 0; s < 2; s++) begin
            for (int op = 0; op < 8; op++) begin
                do_req(0, 32'h8000_0000, 32'h8000_0000, 1'(s), 3'(op));
                drain();
                check($sformatf("sweep_s%0d_op%0d", s, op), 64'(last_q), 64'(sweep_exp[op]));
            end
        end

        // Round-robin with all requesters continuously valid
        pulse_reset();
        for (int k = 0; k < N; k++) set_req(k, $urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        g0 = grant_ids.size();
        wait_grants(n_grants + 5);
        req_valid = '0;
        drain();
        for (int i = 0; i < 5; i++) begin
            if (g0 + i < grant_ids.size()) begin
                check($sformatf("rr_order_%0d", i), 64'(grant_ids[g0+i]), 64'(rr_exp[i]));
                if (i > 0) check($sformatf("rr_spacing_%0d", i),
                                 64'(grant_cyc[g0+i] - grant_cyc[g0+i-1]), 64'd3);
            end
        end

        // Backpressure: requester 1 held in RESP, requester 2 waiting
        rsp_ready = 1'b0;
        do_req(1, 32'h1234, 32'h1234, 1'b0, 3'd1);
        bp_q = cmp_model(32'h1234, 32'h1234, 1'b0, 3'd1, W);
        for (int t = 0; t < 5 && !rsp_valid; t++) cycle();
        set_req(2, 32'hFFFF_FFF0, 32'd3, 1'b1, 3'd2);
        for (int t = 0; t < 5; t++) begin
            cycle();
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_id", 64'(rsp_id), 64'd1);
            check("bp_q", 64'(rsp_q), 64'(bp_q));
            check("bp_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        wait_grants(n_grants + 1);
        req_valid = '0;
        drain();
        check("bp_next_grant", 64'(grant_ids[grant_ids.size()-1]), 64'd2);

        // Reset while a request sits in CMP; pointer first moved to 2
        do_req(1, 32'd7, 32'd9, 1'b0, 3'd0);
        drain();
        do_req(1, 32'd7, 32'd9, 1'b0, 3'd0);
        pulse_reset();
        for (int t = 0; t < 4; t++) begin
            cycle();
            check("rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        set_req(2, 32'd1, 32'd2, 1'b0, 3'd5);
        set_req(0, 32'd3, 32'd3, 1'b0, 3'd4);
        g0 = n_grants;
        cycle();
        check("first_grant_after_rst", 64'(n_grants - g0), 64'd1);
        check("grant_after_rst", 64'(grant_ids[grant_ids.size()-1]), 64'd0);
        req_valid[0] = 1'b0;
        wait_grants(n_grants + 1);
        req_valid = '0;
        drain();
        check("grant_after_rst_2", 64'(grant_ids[grant_ids.size()-1]), 64'd2);

        run16("w16_reserved", 16'h0001, 16'h0002, 1'b0, 3'd6, 1'b0);
        run16("w16_signed_gt", 16'h7FFF, 16'h8000, 1'b1, 3'd2, 1'b1);
        run16("w16_unsigned_gt", 16'h7FFF, 16'h8000, 1'b0, 3'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
